// File: rtl/axil_crossbar_wr_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axil_crossbar_wr_arb
//
// N-master to 1-slave AXI-Lite write path with a local arbiter and a
// transaction lock. One master is granted when the block is idle. Its AW and W
// channels are forwarded to the slave. The grant is held until the B handshake
// for that master completes, and only then is another master considered.
//
// Optional feature (compile-time macro):
//   AXIL_WR_RR_EN  defined   -> round-robin arbitration. The search starts
//                               after the last granted master and wraps.
//                  undefined -> fixed priority. The lowest index with awvalid
//                               wins, and there is no pointer register.
//
// Parameters:
//   NUMBER_MASTER   masters competing for this slave port (>=2)
//   AXI_DATA_WIDTH  W data width (multiple of 8)
//   AXI_ADDR_WIDTH  AW address width
//
// Ports:
//   aclk, aresetn          clock (rising edge), synchronous active-low reset
//   grant_wr               one-hot current grant, all zero when idle
//   m_axil_aw*/w*/b*       per-master AXI-Lite write channels (unpacked data)
//   s_axil_aw*/w*/b*       slave-side AXI-Lite write channels
// -----------------------------------------------------------------------------
module axil_crossbar_wr_arb #(
  parameter int NUMBER_MASTER  = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  output logic [NUMBER_MASTER-1:0]      grant_wr,

  input  logic [AXI_ADDR_WIDTH-1:0]     m_axil_awaddr  [NUMBER_MASTER],
  input  logic [NUMBER_MASTER-1:0]      m_axil_awvalid,
  output logic [NUMBER_MASTER-1:0]      m_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axil_wdata   [NUMBER_MASTER],
  input  logic [AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb   [NUMBER_MASTER],
  input  logic [NUMBER_MASTER-1:0]      m_axil_wvalid,
  output logic [NUMBER_MASTER-1:0]      m_axil_wready,
  output logic [1:0]                    m_axil_bresp   [NUMBER_MASTER],
  output logic [NUMBER_MASTER-1:0]      m_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0]      m_axil_bready,

  output logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  output logic                          s_axil_awvalid,
  input  logic                          s_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  output logic                          s_axil_wvalid,
  input  logic                          s_axil_wready,
  input  logic [1:0]                    s_axil_bresp,
  input  logic                          s_axil_bvalid,
  output logic                          s_axil_bready
);

  localparam int IDX_W = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_RESP
  } state_t;

  state_t                   r_state;
  logic [NUMBER_MASTER-1:0] r_grant;
  logic [IDX_W-1:0]         r_gidx;
  logic                     r_aw_done;
  logic                     r_w_done;
`ifdef AXIL_WR_RR_EN
  logic [IDX_W-1:0]         r_rr_ptr;
`endif

  logic                     w_any_req;
  logic [IDX_W-1:0]         w_arb_idx;
  logic                     w_s_aw_hs;
  logic                     w_s_w_hs;
  logic                     w_s_b_hs;
  logic                     w_aw_fin;
  logic                     w_w_fin;

  assign grant_wr = r_grant;

  // ---------------------------------------------------------------------------
  // Arbitration. Candidates are scanned from lowest to highest priority so the
  // last match in the loop is the winner.
  // ---------------------------------------------------------------------------
`ifdef AXIL_WR_RR_EN
  always_comb begin
    int unsigned v_cand;
    v_cand    = 0;
    w_arb_idx = '0;
    w_any_req = |m_axil_awvalid;
    // Offset NUMBER_MASTER is the last grant itself (lowest priority),
    // offset 1 is the master right after it (highest priority).
    for (int unsigned k = NUMBER_MASTER; k > 0; k--) begin
      v_cand = (32'(r_rr_ptr) + k) % NUMBER_MASTER;
      if (m_axil_awvalid[v_cand]) begin
        w_arb_idx = IDX_W'(v_cand);
      end
    end
  end
`else
  always_comb begin
    w_arb_idx = '0;
    w_any_req = |m_axil_awvalid;
    for (int unsigned k = NUMBER_MASTER; k > 0; k--) begin
      if (m_axil_awvalid[k-1]) begin
        w_arb_idx = IDX_W'(k - 1);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Handshake detection on the slave side
  // ---------------------------------------------------------------------------
  assign w_s_aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_s_w_hs  = s_axil_wvalid  & s_axil_wready;
  assign w_s_b_hs  = s_axil_bvalid  & s_axil_bready;

  // A channel counts as finished if it was already done or completes now.
  assign w_aw_fin  = r_aw_done | w_s_aw_hs;
  assign w_w_fin   = r_w_done  | w_s_w_hs;

  // ---------------------------------------------------------------------------
  // Control FSM: grant, per-channel done flags and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
`ifdef AXIL_WR_RR_EN
      r_rr_ptr  <= IDX_W'(NUMBER_MASTER - 1);
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant <= NUMBER_MASTER'(1) << w_arb_idx;
            r_gidx  <= w_arb_idx;
`ifdef AXIL_WR_RR_EN
            r_rr_ptr <= w_arb_idx;
`endif
            r_state <= ST_XFER;
          end
        end

        ST_XFER: begin
          r_aw_done <= w_aw_fin;
          r_w_done  <= w_w_fin;
          if (w_aw_fin && w_w_fin) begin
            r_state <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (w_s_b_hs) begin
            r_grant   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_grant   <= '0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Slave-side routing from the granted master
  // ---------------------------------------------------------------------------
  always_comb begin
    s_axil_awaddr  = '0;
    s_axil_awvalid = 1'b0;
    s_axil_wdata   = '0;
    s_axil_wstrb   = '0;
    s_axil_wvalid  = 1'b0;
    s_axil_bready  = 1'b0;
    if (r_state != ST_IDLE) begin
      s_axil_awaddr  = m_axil_awaddr[r_gidx];
      s_axil_wdata   = m_axil_wdata[r_gidx];
      s_axil_wstrb   = m_axil_wstrb[r_gidx];
      s_axil_awvalid = m_axil_awvalid[r_gidx] & ~r_aw_done;
      s_axil_wvalid  = m_axil_wvalid[r_gidx]  & ~r_w_done;
    end
    // A slave B that shows up before RESP is left pending (bready held low).
    if (r_state == ST_RESP) begin
      s_axil_bready = m_axil_bready[r_gidx];
    end
  end

  // ---------------------------------------------------------------------------
  // Master-side returns: only the granted master sees ready/response
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned m = 0; m < NUMBER_MASTER; m++) begin
      m_axil_awready[m] = 1'b0;
      m_axil_wready[m]  = 1'b0;
      m_axil_bvalid[m]  = 1'b0;
      m_axil_bresp[m]   = 2'b00;
      if (r_grant[m]) begin
        m_axil_bresp[m] = s_axil_bresp;
        if (r_state == ST_XFER) begin
          m_axil_awready[m] = s_axil_awready & ~r_aw_done;
          m_axil_wready[m]  = s_axil_wready  & ~r_w_done;
        end
        if (r_state == ST_RESP) begin
          m_axil_bvalid[m] = s_axil_bvalid;
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_crossbar_wr_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_axil_crossbar_wr_arb
//
// Directed bench for the AXI-Lite write arbiter. Tests push the expected grant,
// slave AW/W beats and master B responses into queues. A monitor pops and
// compares them whenever the DUT shows a grant or completes a handshake.
// Inputs are driven on the falling edge. Outputs are sampled 1ns before the
// rising edge.
// -----------------------------------------------------------------------------
module tb_axil_crossbar_wr_arb;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [NM-1:0]   grant_wr;

  logic [AW-1:0]   m_awaddr  [NM];
  logic [NM-1:0]   m_awvalid;
  logic [NM-1:0]   m_awready;
  logic [DW-1:0]   m_wdata   [NM];
  logic [DW/8-1:0] m_wstrb   [NM];
  logic [NM-1:0]   m_wvalid;
  logic [NM-1:0]   m_wready;
  logic [1:0]      m_bresp   [NM];
  logic [NM-1:0]   m_bvalid;
  logic [NM-1:0]   m_bready;

  logic [AW-1:0]   s_awaddr;
  logic            s_awvalid;
  logic            s_awready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wvalid;
  logic            s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready;

  logic [1:0]      slv_bresp;

  int checks = 0;
  int errors = 0;

  logic [63:0] q_grant[$];
  logic [63:0] q_aw[$];
  logic [63:0] q_w[$];
  logic [63:0] q_b[$];

  always #5 aclk = ~aclk;

  axil_crossbar_wr_arb #(
    .NUMBER_MASTER  (NM),
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .grant_wr       (grant_wr),
    .m_axil_awaddr  (m_awaddr),
    .m_axil_awvalid (m_awvalid),
    .m_axil_awready (m_awready),
    .m_axil_wdata   (m_wdata),
    .m_axil_wstrb   (m_wstrb),
    .m_axil_wvalid  (m_wvalid),
    .m_axil_wready  (m_wready),
    .m_axil_bresp   (m_bresp),
    .m_axil_bvalid  (m_bvalid),
    .m_axil_bready  (m_bready),
    .s_axil_awaddr  (s_awaddr),
    .s_axil_awvalid (s_awvalid),
    .s_axil_awready (s_awready),
    .s_axil_wdata   (s_wdata),
    .s_axil_wstrb   (s_wstrb),
    .s_axil_wvalid  (s_wvalid),
    .s_axil_wready  (s_wready),
    .s_axil_bresp   (s_bresp),
    .s_axil_bvalid  (s_bvalid),
    .s_axil_bready  (s_bready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input int m, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
    q_grant.push_back(64'(4'(1) << m));
    q_aw.push_back(64'(addr));
    q_w.push_back(64'({data, strb}));
    q_b.push_back(64'(m * 4 + int'(resp)));
  endtask

  task automatic check_idle(input string name);
    logic [7:0] br;
    br = {m_bresp[3], m_bresp[2], m_bresp[1], m_bresp[0]};
    check({name, "_grant"}, 64'(grant_wr), 64'(0));
    check({name, "_valid_ready"},
          64'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 64'(0));
    check({name, "_awaddr"}, 64'(s_awaddr), 64'(0));
    check({name, "_wdata_strb"}, 64'({s_wdata, s_wstrb}), 64'(0));
    check({name, "_bresp"}, 64'(br), 64'(0));
  endtask

  // Master-side write. Must be entered on a falling edge and returns on one.
  task automatic mwrite(input int m, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
    bit aw_d = 0;
    bit w_d  = 0;
    bit b_d  = 0;
    int n    = 0;
    m_awaddr[m]  = addr;
    m_wdata[m]   = data;
    m_wstrb[m]   = strb;
    m_awvalid[m] = 1'b1;
    m_wvalid[m]  = 1'b1;
    while (!b_d && n < 200) begin
      #4;
      if (m_awvalid[m] && m_awready[m]) aw_d = 1;
      if (m_wvalid[m] && m_wready[m])   w_d  = 1;
      if (m_bvalid[m] && m_bready[m])   b_d  = 1;
      @(negedge aclk);
      n++;
      if (aw_d) m_awvalid[m] = 1'b0;
      if (w_d)  m_wvalid[m]  = 1'b0;
    end
    m_awvalid[m] = 1'b0;
    m_wvalid[m]  = 1'b0;
    check($sformatf("txn_done_m%0d", m), 64'(b_d), 64'(1));
  endtask

  task automatic mburst(input int m);
    for (int k = 0; k < 2; k++) begin
      mwrite(m, 32'h1000 + 32'(m) * 32'h100 + 32'(k) * 4, 32'hC0DE_0000 + 32'(m * 16 + k), 4'hF);
    end
  endtask

  // Slave: raises B once an AW and a W have both been accepted.
  task automatic slave_loop();
    int   aw_cnt = 0;
    int   w_cnt  = 0;
    logic nb     = 1'b0;
    forever begin
      @(negedge aclk);
      s_bvalid = nb;
      s_bresp  = nb ? slv_bresp : 2'b00;
      #4;
      if (!aresetn) begin
        aw_cnt = 0;
        w_cnt  = 0;
        nb     = 1'b0;
      end else begin
        if (s_awvalid && s_awready) aw_cnt++;
        if (s_wvalid && s_wready)   w_cnt++;
        if (s_bvalid && s_bready) begin
          aw_cnt--;
          w_cnt--;
        end
        nb = (aw_cnt > 0) && (w_cnt > 0);
      end
    end
  endtask

  task automatic monitor_loop();
    logic [NM-1:0] g_prev = '0;
    forever begin
      @(negedge aclk);
      #4;
      if (grant_wr !== g_prev && grant_wr != '0) begin
        if (q_grant.size() == 0) begin
          checks++; errors++;
          $display("FAIL grant_unexpected: got %b expected none", grant_wr);
        end else check("grant", 64'(grant_wr), q_grant.pop_front());
      end
      g_prev = grant_wr;
      if (s_awvalid && s_awready) begin
        if (q_aw.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected: got %0h expected none", s_awaddr);
        end else check("aw_addr", 64'(s_awaddr), q_aw.pop_front());
      end
      if (s_wvalid && s_wready) begin
        if (q_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected: got %0h expected none", s_wdata);
        end else check("w_data_strb", 64'({s_wdata, s_wstrb}), q_w.pop_front());
      end
      for (int m = 0; m < NM; m++) begin
        if (m_bvalid[m] && m_bready[m]) begin
          if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: got master %0d resp %0d expected none", m, m_bresp[m]);
          end else check("b_master_resp", 64'(m * 4 + int'(m_bresp[m])), q_b.pop_front());
        end
      end
    end
  endtask

  initial begin
    int  n;
    bit  seen;

    for (int m = 0; m < NM; m++) begin
      m_awaddr[m] = '0;
      m_wdata[m]  = '0;
      m_wstrb[m]  = '0;
    end
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '1;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    s_bvalid  = 1'b0;
    s_bresp   = 2'b00;
    slv_bresp = 2'b00;

    fork
      monitor_loop();
      slave_loop();
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    #4;
    check_idle("reset");
    @(negedge aclk);
    aresetn = 1'b1;

    // Contention: four masters, two writes each
`ifdef AXIL_WR_RR_EN
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < NM; m++)
        expect_txn(m, 32'h1000 + 32'(m) * 32'h100 + 32'(k) * 4, 32'hC0DE_0000 + 32'(m * 16 + k), 4'hF, 2'b00);
`else
    for (int m = 0; m < NM; m++)
      for (int k = 0; k < 2; k++)
        expect_txn(m, 32'h1000 + 32'(m) * 32'h100 + 32'(k) * 4, 32'hC0DE_0000 + 32'(m * 16 + k), 4'hF, 2'b00);
`endif
    fork
      mburst(0);
      mburst(1);
      mburst(2);
      mburst(3);
    join

    // Single write from M1, with grant latency
    @(negedge aclk);
    expect_txn(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00);
    fork
      mwrite(1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      begin
        #4;
        check("single_pre_grant", 64'(grant_wr), 64'(0));
        check("single_pre_awvalid", 64'(s_awvalid), 64'(0));
        @(negedge aclk);
        #4;
        check("single_grant_now", 64'(grant_wr), 64'(4'b0010));
        check("single_s_awvalid", 64'(s_awvalid), 64'(1));
        check("single_s_awaddr", 64'(s_awaddr), 64'(32'h10));
      end
    join
    #4;
    check("single_back_idle", 64'(grant_wr), 64'(0));
    @(negedge aclk);

    // W accepted before AW
    s_awready = 1'b0;
    expect_txn(1, 32'h44, 32'h0BAD_F00D, 4'h5, 2'b00);
    fork
      mwrite(1, 32'h44, 32'h0BAD_F00D, 4'h5);
      begin
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
          #4;
          if (s_wvalid && s_wready) seen = 1;
          @(negedge aclk);
          n++;
        end
        check("order_w_seen", 64'(seen), 64'(1));
        repeat (2) begin
          #4;
          check("order_s_awvalid_wait", 64'(s_awvalid), 64'(1));
          check("order_s_wvalid_done", 64'(s_wvalid), 64'(0));
          check("order_m_wready_done", 64'(m_wready[1]), 64'(0));
          check("order_no_resp", 64'({m_bvalid[1], s_bready}), 64'(0));
          @(negedge aclk);
        end
        s_awready = 1'b1;
      end
    join

    // Lock: M0 requests while M2 holds the grant
    @(negedge aclk);
    s_awready   = 1'b0;
    m_bready[2] = 1'b0;
    expect_txn(2, 32'h200, 32'hA5A5_0002, 4'hF, 2'b00);
    expect_txn(0, 32'h300, 32'h1234_5678, 4'h3, 2'b00);
    fork
      mwrite(2, 32'h200, 32'hA5A5_0002, 4'hF);
      begin
        @(negedge aclk);
        mwrite(0, 32'h300, 32'h1234_5678, 4'h3);
      end
      begin
        int  ln = 0;
        int  hold = 0;
        bit  done = 0;
        @(negedge aclk);
        while (!done && ln < 60) begin
          #4;
          check("lock_grant", 64'(grant_wr), 64'(4'b0100));
          check("lock_m0_awready", 64'(m_awready[0]), 64'(0));
          if (m_bvalid[2] && m_bready[2]) done = 1;
          if (m_bvalid[2]) hold++;
          @(negedge aclk);
          ln++;
          if (ln == 3) s_awready = 1'b1;
          if (hold >= 2) m_bready[2] = 1'b1;
        end
        check("lock_released", 64'(done), 64'(1));
      end
    join
    s_awready   = 1'b1;
    m_bready[2] = 1'b1;

    // B backpressure with SLVERR
    @(negedge aclk);
    m_bready[3] = 1'b0;
    slv_bresp   = 2'b10;
    expect_txn(3, 32'h3C, 32'h55AA_55AA, 4'hF, 2'b10);
    fork
      mwrite(3, 32'h3C, 32'h55AA_55AA, 4'hF);
      begin
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
          #4;
          if (m_bvalid[3]) seen = 1;
          @(negedge aclk);
          n++;
        end
        check("bp_bvalid_seen", 64'(seen), 64'(1));
        repeat (3) begin
          #4;
          check("bp_bvalid_held", 64'(m_bvalid[3]), 64'(1));
          check("bp_bresp", 64'(m_bresp[3]), 64'(2'b10));
          check("bp_s_bready", 64'(s_bready), 64'(0));
          @(negedge aclk);
        end
        m_bready[3] = 1'b1;
      end
    join
    slv_bresp = 2'b00;

    // Reset in XFER after AW is done; no W, no B
    @(negedge aclk);
    s_wready = 1'b0;
    q_grant.push_back(64'(4'b0010));
    q_aw.push_back(64'(32'h80));
    m_awaddr[1]  = 32'h80;
    m_wdata[1]   = 32'h7777_8888;
    m_wstrb[1]   = 4'hF;
    m_awvalid[1] = 1'b1;
    m_wvalid[1]  = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      #4;
      if (s_awvalid && s_awready) seen = 1;
      @(negedge aclk);
      n++;
    end
    check("rst_aw_seen", 64'(seen), 64'(1));
    m_awvalid[1] = 1'b0;
    #4;
    check("rst_xfer_grant", 64'(grant_wr), 64'(4'b0010));
    check("rst_aw_done_w_pending", 64'({s_awvalid, s_wvalid}), 64'(2'b01));
    @(negedge aclk);
    aresetn     = 1'b0;
    m_wvalid[1] = 1'b0;
    @(negedge aclk);
    aresetn  = 1'b1;
    s_wready = 1'b1;
    #4;
    check_idle("mid_reset");
    @(negedge aclk);
    expect_txn(2, 32'h90, 32'h0000_0042, 4'h1, 2'b00);
    mwrite(2, 32'h90, 32'h0000_0042, 4'h1);

    repeat (4) @(negedge aclk);
    check("left_grant", 64'(q_grant.size()), 64'(0));
    check("left_aw", 64'(q_aw.size()), 64'(0));
    check("left_w", 64'(q_w.size()), 64'(0));
    check("left_b", 64'(q_b.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
